// File: rtl/if_bus_pkg.sv
// Shared types for the txd/rxd/dat register bus responder.
// Opcodes, FSM states, error data and response word layout.
package if_bus_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_WR  = 2'b01,
    OP_RD  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    op_e         op;
    logic [13:0] addr;
  } cmd_t;

  localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

  localparam int RXD_ERR_BIT = 15;
  localparam int RXD_CNT_W   = 8;

  function automatic logic [15:0] make_rxd(
    input logic                 err,
    input logic [RXD_CNT_W-1:0] cnt
  );
    logic [15:0] r;
    r = '0;
    r[RXD_ERR_BIT] = err;
    r[RXD_CNT_W-1:0] = cnt;
    return r;
  endfunction

endpackage

// File: rtl/if_bus_responder_sync2.sv
// Two-flop synchronizer for the asynchronous bus request.
// Reset clears both stages so the request reads idle.
module if_sync2 (
  input  logic ck,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // shift the async input through two stages
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/if_bus_responder.sv
// Slave responder: register file behind a 4-phase en/rdy handshake.
// Commands captured on the synchronized en rising edge.
module if_bus_responder
  import if_bus_pkg::*;
#(
  parameter int          ADDR_W   = 4,
  parameter int          WAIT_CYC = 2,
  parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [15:0] sync_txd,
  inout  wire  [15:0] sync_dat,
  output logic [15:0] sync_rxd,
  input  logic        async_en,
  output logic        async_rdy
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  logic en_s;

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] wdat_q, wdat_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] rxd_q, rxd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  txn_q, txn_d;
  logic        rdy_q, rdy_d;
  logic        en_prev_q;

  logic [15:0]       regs_q [DEPTH];
  logic              we;
  logic [ADDR_W-1:0] idx;
  logic              addr_err;
  logic              err;
  logic              drive;

  if_sync2 u_sync (
    .ck    (ck),
    .rst_n (rst_n),
    .d_i   (async_en),
    .q_o   (en_s)
  );

  assign idx      = cmd_q.addr[ADDR_W-1:0];
  assign addr_err = |(cmd_q.addr >> ADDR_W);
  assign err      = (cmd_q.op == OP_ILL) || addr_err;

  // next-state: handshake FSM, wait counter, op execution
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    rxd_d   = rxd_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    rdy_d   = rdy_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_s && !en_prev_q) begin
          cmd_d   = cmd_t'(sync_txd);
          wdat_d  = sync_dat;
          cnt_d   = WAIT_LD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          txn_d = txn_q + 8'd1;
          rxd_d = make_rxd(err, txn_d);
          if (err) begin
            rdata_d = ERR_DATA;
          end else if (cmd_q.op == OP_RD) begin
            rdata_d = regs_q[idx];
          end
          we      = !err && (cmd_q.op == OP_WR);
          rdy_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (!en_s) begin
          rdy_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // control and response registers
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      wdat_q    <= '0;
      rdata_q   <= '0;
      rxd_q     <= '0;
      cnt_q     <= '0;
      txn_q     <= '0;
      rdy_q     <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      wdat_q    <= wdat_d;
      rdata_q   <= rdata_d;
      rxd_q     <= rxd_d;
      cnt_q     <= cnt_d;
      txn_q     <= txn_d;
      rdy_q     <= rdy_d;
      en_prev_q <= en_s;
    end
  end

  // register file, written only by a clean WR
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[idx] <= wdat_q;
    end
  end

  // read data goes on the bus only while a RD response is held
  assign drive     = (state_q == ST_RESP) && (cmd_q.op == OP_RD);
  assign sync_dat  = drive ? rdata_q : 16'hzzzz;
  assign sync_rxd  = rxd_q;
  assign async_rdy = rdy_q;

endmodule

// File: tb/tb_if_bus_responder.sv
// Directed bench for if_bus_responder: vector table plus
// latency, wrap, mid-op reset and early en drop sequences.
module tb_if_bus_responder;

  logic        ck = 1'b0;
  logic        rst_n;
  logic [15:0] txd;
  logic [2:0]  en_v;
  logic        tb_drv;
  logic [15:0] tb_dat;

  wire  [2:0]  rdy_v;
  wire  [15:0] rxd0, rxd1, rxd2;
  tri1  [15:0] dat0, dat1, dat2;

  int checks = 0;
  int errors = 0;

  assign dat0 = tb_drv ? tb_dat : 16'hzzzz;

  always #5 ck = ~ck;

  if_bus_responder #(.ADDR_W(4), .WAIT_CYC(2)) u_m (
    .ck(ck), .rst_n(rst_n), .sync_txd(txd), .sync_dat(dat0),
    .sync_rxd(rxd0), .async_en(en_v[0]), .async_rdy(rdy_v[0])
  );

  if_bus_responder #(.ADDR_W(4), .WAIT_CYC(0)) u_w0 (
    .ck(ck), .rst_n(rst_n), .sync_txd(txd), .sync_dat(dat1),
    .sync_rxd(rxd1), .async_en(en_v[1]), .async_rdy(rdy_v[1])
  );

  if_bus_responder #(.ADDR_W(4), .WAIT_CYC(5)) u_w5 (
    .ck(ck), .rst_n(rst_n), .sync_txd(txd), .sync_dat(dat2),
    .sync_rxd(rxd2), .async_en(en_v[2]), .async_rdy(rdy_v[2])
  );

  typedef struct {
    logic [15:0] txd;
    logic [15:0] wd;
    bit          drv;
    logic [15:0] rxd;
    logic [15:0] dat;
  } vec_t;

  vec_t vt[11];

  function automatic logic rdy_of(input int s);
    return rdy_v[s];
  endfunction

  function automatic logic [15:0] rxd_of(input int s);
    case (s)
      0:       return rxd0;
      1:       return rxd1;
      default: return rxd2;
    endcase
  endfunction

  function automatic logic [15:0] dat_of(input int s);
    case (s)
      0:       return dat0;
      1:       return dat1;
      default: return dat2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input int s, input logic [15:0] c,
                         input logic [15:0] wd, input bit drv,
                         output logic [15:0] rxd,
                         output logic [15:0] rdat, output int lat);
    bit ok;
    bit gone;
    @(negedge ck);
    txd    = c;
    tb_dat = wd;
    tb_drv = drv && (s == 0);
    en_v[s] = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge ck);
      lat++;
      @(negedge ck);
      if (lat == 3) begin
        tb_drv = 1'b0;
        txd    = 16'h4000;
        tb_dat = 16'h5A5A;
      end
      if (rdy_of(s)) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("rdy_rise_timeout s%0d", s), 32'(ok), 32'd1);
    rxd  = rxd_of(s);
    rdat = dat_of(s);
    tb_drv  = 1'b0;
    en_v[s] = 1'b0;
    gone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck);
      if (!rdy_of(s)) begin
        gone = 1'b1;
        break;
      end
    end
    chk($sformatf("rdy_fall_timeout s%0d", s), 32'(gone), 32'd1);
    chk($sformatf("dat_released_after s%0d", s), 32'(dat_of(s)),
        32'h0000FFFF);
    repeat (2) @(negedge ck);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, d;
    int          lat;
    int          pulses;

    vt[0]  = '{16'h4003, 16'h1234, 1'b1, 16'h0001, 16'hFFFF};
    vt[1]  = '{16'h8003, 16'h0000, 1'b0, 16'h0002, 16'h1234};
    vt[2]  = '{16'h8010, 16'h0000, 1'b0, 16'h8003, 16'hDEAD};
    vt[3]  = '{16'h4005, 16'hBEEF, 1'b1, 16'h0004, 16'hFFFF};
    vt[4]  = '{16'hC005, 16'h0000, 1'b1, 16'h8005, 16'hFFFF};
    vt[5]  = '{16'h8005, 16'h0000, 1'b0, 16'h0006, 16'hBEEF};
    vt[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0007, 16'hFFFF};
    vt[7]  = '{16'h7FFF, 16'h1111, 1'b1, 16'h8008, 16'hFFFF};
    vt[8]  = '{16'h800F, 16'h0000, 1'b0, 16'h0009, 16'h0000};
    vt[9]  = '{16'h400F, 16'hAAAA, 1'b1, 16'h000A, 16'hFFFF};
    vt[10] = '{16'h800F, 16'h0000, 1'b0, 16'h000B, 16'hAAAA};

    rst_n  = 1'b1;
    en_v   = '0;
    tb_drv = 1'b0;
    tb_dat = '0;
    txd    = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge ck);
    chk("reset_rdy", 32'(rdy_v), 32'd0);
    chk("reset_rxd", 32'(rxd0), 32'd0);
    chk("reset_dat", 32'(dat0), 32'h0000FFFF);
    rst_n = 1'b1;
    repeat (2) @(negedge ck);

    for (int i = 0; i < 11; i++) begin
      run_cmd(0, vt[i].txd, vt[i].wd, vt[i].drv, r, d, lat);
      chk($sformatf("vec%0d_rxd", i), 32'(r), 32'(vt[i].rxd));
      chk($sformatf("vec%0d_dat", i), 32'(d), 32'(vt[i].dat));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd6);
    end

    run_cmd(1, 16'h0000, 16'h0000, 1'b0, r, d, lat);
    chk("w0_lat", 32'(lat), 32'd4);
    chk("w0_rxd", 32'(r), 32'h0001);
    run_cmd(2, 16'h8000, 16'h0000, 1'b0, r, d, lat);
    chk("w5_lat", 32'(lat), 32'd9);
    chk("w5_rxd", 32'(r), 32'h0001);
    chk("w5_dat", 32'(d), 32'h0000);

    for (int i = 0; i < 255; i++) begin
      run_cmd(1, 16'h0000, 16'h0000, 1'b0, r, d, lat);
    end
    chk("wrap_256_rxd", 32'(r), 32'h0000);
    run_cmd(1, 16'h0000, 16'h0000, 1'b0, r, d, lat);
    chk("wrap_257_rxd", 32'(r), 32'h0001);

    @(negedge ck);
    txd     = 16'h4007;
    tb_dat  = 16'h7777;
    tb_drv  = 1'b1;
    en_v[0] = 1'b1;
    repeat (3) @(posedge ck);
    @(negedge ck);
    tb_drv = 1'b0;
    @(posedge ck);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 32'(rdy_v[0]), 32'd0);
    chk("midrst_rxd", 32'(rxd0), 32'd0);
    chk("midrst_dat", 32'(dat0), 32'h0000FFFF);
    en_v[0] = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    repeat (3) @(negedge ck);
    run_cmd(0, 16'h8007, 16'h0000, 1'b0, r, d, lat);
    chk("midrst_rd_dat", 32'(d), 32'h0000);
    chk("midrst_rd_rxd", 32'(r), 32'h0001);

    @(negedge ck);
    txd     = 16'h0000;
    en_v[0] = 1'b1;
    repeat (3) @(posedge ck);
    @(negedge ck);
    en_v[0] = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge ck);
      if (rdy_v[0]) pulses++;
    end
    chk("drop_pulse_cycles", 32'(pulses), 32'd1);
    chk("drop_rxd", 32'(rxd0), 32'h0002);
    run_cmd(0, 16'h0000, 16'h0000, 1'b0, r, d, lat);
    chk("after_drop_rxd", 32'(r), 32'h0003);
    chk("after_drop_lat", 32'(lat), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
